// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and capture FSM state encoding.
`default_nettype none
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    WAIT_VE = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } cap_state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_sampler.sv
// Samples the VGA stream at mid-pixel (vgaclk falling edge seen in clk) and flags edges.
`default_nettype none
module vga_sync_sampler
  import vga_pkg::*;
#(
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vgaclk,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_b,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        smp,
  output logic        vs_act,
  output logic        blank,
  output logic [23:0] rgb,
  output logic        vs_rise,
  output logic        blank_fall,
  output logic        hs_edge
);

  logic vc_q;
  logic vs_prev;
  logic bl_prev;
  logic hs_prev;
  logic hs_act;

  // Previous values only advance on sample cycles so edges are pixel-to-pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      vc_q    <= 1'b0;
      vs_prev <= 1'b0;
      bl_prev <= 1'b0;
      hs_prev <= 1'b0;
    end else begin
      vc_q <= vgaclk;
      if (smp) begin
        vs_prev <= vs_act;
        bl_prev <= blank_b;
        hs_prev <= hs_act;
      end
    end
  end

  assign smp        = vc_q & ~vgaclk;
  assign vs_act     = (vsync == SYNC_POL);
  assign hs_act     = (hsync == SYNC_POL);
  assign blank      = blank_b;
  assign rgb        = {r, g, b};
  assign vs_rise    = smp & vs_act & ~vs_prev;
  assign blank_fall = smp & bl_prev & ~blank_b;
  assign hs_edge    = smp & hs_act & ~hs_prev;

endmodule
`default_nettype wire

// File: rtl/vga_capture.sv
// Captures one VGA frame into a linear frame-buffer write port, checking geometry.
`default_nettype none
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19,
  parameter int SYNC_POL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              vgaclk,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank_b,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [9:0]        lines
);

  // x counts one past H_ACTIVE and then holds, so overlong lines never wrap.
  localparam int                XW        = $clog2(H_ACTIVE + 2);
  localparam logic [XW-1:0]     X_END     = XW'(H_ACTIVE);
  localparam logic [XW-1:0]     X_ONE     = XW'(1);
  localparam logic [9:0]        Y_END     = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);

  logic              smp, vs_act, blank, vs_rise, blank_fall, hs_edge;
  logic [23:0]       rgb;
  cap_state_t        state;
  logic [XW-1:0]     x;
  logic [9:0]        y;
  logic [9:0]        y_end;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] line_base;
  logic              in_range;

  vga_sync_sampler #(
    .SYNC_POL (SYNC_POL[0])
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .vgaclk     (vgaclk),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank_b    (blank_b),
    .r          (r),
    .g          (g),
    .b          (b),
    .smp        (smp),
    .vs_act     (vs_act),
    .blank      (blank),
    .rgb        (rgb),
    .vs_rise    (vs_rise),
    .blank_fall (blank_fall),
    .hs_edge    (hs_edge)
  );

  // Line end is folded in first so a coincident frame end sees the updated count.
  assign y_end    = blank_fall ? sat_inc10(y) : y;
  assign in_range = (x < X_END) && (y < Y_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      lines      <= '0;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      line_base  <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT_VS;
            busy      <= 1'b1;
            err       <= 1'b0;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            line_base <= '0;
          end
        end
        WAIT_VS: begin
          if (smp && vs_act) begin
            state     <= WAIT_VE;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            line_base <= '0;
          end
        end
        WAIT_VE: begin
          if (smp && !vs_act) state <= CAPTURE;
        end
        CAPTURE: begin
          if (smp) begin
            if (blank) begin
              if (in_range) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= rgb;
              end else begin
                err <= 1'b1;
              end
              if (x <= X_END) x <= x + X_ONE;
              addr <= addr + A_ONE;
            end
            if (hs_edge && blank) err <= 1'b1;
            if (blank_fall) begin
              if (x != X_END) err <= 1'b1;
              y         <= y_end;
              x         <= '0;
              line_base <= line_base + LINE_STEP;
              addr      <= line_base + LINE_STEP;
            end
            if (vs_rise) begin
              if (y_end != Y_END) err <= 1'b1;
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              lines      <= y_end;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on an 8x4 geometry with vgaclk = clk/2.
`timescale 1ns/1ps
`default_nettype none
module tb_vga_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          vgaclk = 1'b0;
  logic          hsync = 1'b1;
  logic          vsync = 1'b1;
  logic          blank_b = 1'b0;
  logic [7:0]    r = '0, g = '0, b = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          busy, frame_done, err;
  logic [9:0]    lines;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  logic [AW-1:0] log_addr[$];
  logic [23:0]   log_data[$];

  int         cfg_lines = 4;
  int         cfg_short_y = -1;
  int         cfg_short_len = H;
  int         cfg_start_y = -1;
  int         cfg_glitch_y = -1;
  logic [7:0] cfg_b = 8'h5A;
  logic       start_req = 1'b0;

  always #5 clk = ~clk;

  vga_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .SYNC_POL (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vgaclk     (vgaclk),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank_b    (blank_b),
    .r          (r),
    .g          (g),
    .b          (b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .lines      (lines)
  );

  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One pixel = two clk cycles: vgaclk high then low; sampled on the falling half.
  task automatic pix(input logic hs, input logic vs, input logic bl,
                     input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
    @(negedge clk);
    vgaclk = 1'b1; hsync = hs; vsync = vs; blank_b = bl;
    r = pr; g = pg; b = pb;
    start = start_req; start_req = 1'b0;
    @(negedge clk);
    vgaclk = 1'b0; start = 1'b0;
  endtask

  task automatic vsync_pulse();
    pix(1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
    pix(1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
    pix(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
    pix(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
  endtask

  task automatic gen_frame();
    int len;
    vsync_pulse();
    for (int y = 0; y < cfg_lines; y++) begin
      if (y == cfg_start_y) start_req = 1'b1;
      pix(1'b0, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
      pix(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
      len = (y == cfg_short_y) ? cfg_short_len : H;
      for (int x = 0; x < len; x++)
        pix((y == cfg_glitch_y && x == 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, 8'(y), 8'(x), cfg_b);
    end
    pix(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
    pix(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200 && fd_cnt < target; i++) @(posedge clk);
    #2;
    check("frame_done_count", fd_cnt, target);
  endtask

  // Expected writes: rows 0..nl-1, address y*H+x regardless of earlier short lines.
  task automatic verify(input int nl, input int sy, input int slen, input logic [7:0] bv);
    int k;
    int len;
    k = 0;
    for (int y = 0; y < nl; y++) begin
      len = (y == sy) ? slen : H;
      for (int x = 0; x < len; x++) begin
        if (k < log_addr.size()) begin
          check("wr_addr", 32'(log_addr[k]), 32'(y * H + x));
          check("wr_data", 32'(log_data[k]), {8'h00, 8'(y), 8'(x), bv});
        end
        k++;
      end
    end
    check("wr_count", log_addr.size(), k);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_lines", lines, 0);
    @(negedge clk); rst = 1'b0;

    // Clean 8x4 frame.
    clear_log();
    pulse_start();
    @(posedge clk); #1;
    check("busy_after_start", busy, 1);
    gen_frame(); vsync_pulse(); wait_done(1);
    verify(4, -1, H, 8'h5A);
    check("t1_err", err, 0);
    check("t1_lines", lines, 4);
    check("t1_busy", busy, 0);

    // Line 2 one pixel short: line 3 realigns to address 24.
    clear_log();
    cfg_short_y = 2; cfg_short_len = 7;
    pulse_start();
    gen_frame(); vsync_pulse(); wait_done(2);
    verify(4, 2, 7, 8'h5A);
    check("t2_err", err, 1);
    check("t2_lines", lines, 4);
    cfg_short_y = -1; cfg_short_len = H;

    // Start mid-frame: only the following frame is captured.
    clear_log();
    cfg_start_y = 1; cfg_b = 8'hA5;
    gen_frame();
    cfg_start_y = -1; cfg_b = 8'h5A;
    check("t3_no_midframe_wr", log_addr.size(), 0);
    gen_frame(); vsync_pulse(); wait_done(3);
    verify(4, -1, H, 8'h5A);
    check("t3_err", err, 0);

    // Reset after 10 writes aborts; a fresh capture then succeeds.
    clear_log();
    pulse_start();
    fork
      gen_frame();
      begin
        int i;
        i = 0;
        while (log_addr.size() < 10 && i < 2000) begin
          @(posedge clk);
          i++;
        end
        check("t4_reach_10_writes", 32'(i < 2000), 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("t4_rst_wr_en", wr_en, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_err", err, 0);
        check("t4_rst_lines", lines, 0);
        @(negedge clk); rst = 1'b0;
      end
    join
    check("t4_writes_after_rst", log_addr.size(), 10);
    clear_log();
    pulse_start();
    gen_frame(); vsync_pulse(); wait_done(4);
    verify(4, -1, H, 8'h5A);
    check("t4_err", err, 0);
    check("t4_lines", lines, 4);

    // Five active lines: fifth line dropped.
    clear_log();
    cfg_lines = 5;
    pulse_start();
    gen_frame(); vsync_pulse(); wait_done(5);
    verify(4, -1, H, 8'h5A);
    check("t5_err", err, 1);
    check("t5_lines", lines, 5);
    cfg_lines = 4;

    // hsync edge during active video flags an error but writes are intact.
    clear_log();
    cfg_glitch_y = 1;
    pulse_start();
    gen_frame(); vsync_pulse(); wait_done(6);
    verify(4, -1, H, 8'h5A);
    check("t6_err", err, 1);
    check("t6_lines", lines, 4);
    cfg_glitch_y = -1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the platform VGA output. Decodes a VGA-timed stream (vgaclk, hsync, vsync, blank_b, r/g/b) in the system clock domain and writes exactly one captured frame into a linear frame-buffer write port.
- Sits beside the vga block in the platform top. Used for loopback self-check of the video path and for frame-dump capture.

Parameters:
H_ACTIVE, 640, expected active pixels per line
V_ACTIVE, 480, expected active lines per frame
ADDR_W, 19, frame-buffer address width; must satisfy 2**ADDR_W >= H_ACTIVE*V_ACTIVE
SYNC_POL, 0, sync active level (0 = active-low hsync/vsync)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that arms capture of the next frame
vgaclk  input  1  pixel clock from vga, treated as data and sampled by clk
hsync  input  1  horizontal sync
vsync  input  1  vertical sync
blank_b  input  1  high during active video
r  input  8  red
g  input  8  green
b  input  8  blue
wr_en  output  1  frame-buffer write strobe
wr_addr  output  ADDR_W  linear pixel address y*H_ACTIVE+x
wr_data  output  24  {r,g,b}
busy  output  1  high from start accepted until frame_done
frame_done  output  1  one-cycle pulse at end of capture
err  output  1  sticky geometry error; cleared on start
lines  output  10  active lines counted in last capture

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM to IDLE, counters 0. Reset mid-capture aborts with no further writes; err cleared.
- Sampling: vgaclk registered once (vc_q). smp = vc_q & ~vgaclk (vgaclk falling edge, mid-pixel). hsync, vsync, blank_b, r, g, b are taken on smp cycles only.
- vs_act = (vsync == SYNC_POL), evaluated at smp. Edge detects on vs_act and blank_b use the previous smp-sampled values.
- FSM:
  - IDLE: start -> WAIT_VS; busy=1, err=0, counters 0.
  - WAIT_VS: at smp with vs_act=1 -> WAIT_VE. Discards any partial frame in progress.
  - WAIT_VE: at smp with vs_act=0 -> CAPTURE.
  - CAPTURE: at smp with blank_b=1:
    - Write pixel: wr_en=1 on the next clk cycle for exactly one cycle, wr_addr=addr, wr_data={r,g,b}.
    - Then x++, addr++.
    - Pixels with x >= H_ACTIVE, or while y >= V_ACTIVE, are not written; each sets err.
  - CAPTURE, blank_b falling edge (1->0 at smp): if x != H_ACTIVE set err; y++; x=0.
  - CAPTURE, vs_act rising edge -> DONE; if y != V_ACTIVE set err.
  - DONE: one cycle. frame_done=1, busy=0, lines=y (saturates at 1023) -> IDLE.
- Address: addr is an incrementing counter, no multiplier. If a line ends short, addr is realigned to y*H_ACTIVE via a running line-base register (line_base += H_ACTIVE at each line end).
- start outside IDLE is ignored.
- Write latency: 1 clk after the smp cycle. wr_en is never asserted outside CAPTURE.
- hsync is monitored only: a hsync active edge during blank_b=1 sets err.
- Simultaneous blank_b fall and vs_act rise at the same smp: line end is processed first (y++), then the frame end.

Decomposition:
- Package vga_pkg: default timing constants (H_ACTIVE, V_ACTIVE, porches, sync widths) shared with the vga block, plus the FSM state enum typedef {IDLE, WAIT_VS, WAIT_VE, CAPTURE, DONE}.
- One sub-module, vga_sync_sampler: registers vgaclk, produces smp, and delivers smp-aligned copies of hsync, vsync, blank_b and rgb together with their edge flags.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4, vgaclk=clk/2, pixel value = {y,x,8'h5A}, start pulsed -> 32 writes, addr 0..31 in order, wr_data[23:16]=y, frame_done once, lines=4, err=0.
- Same stimulus but line 2 has 7 pixels -> 31 writes; line 3 starts at addr 24; err=1, lines=4.
- Start issued mid-frame -> no write until the next vsync edge is seen; the first write has addr 0 and carries the pixel (0,0) of the following frame.
- rst asserted after 10 writes -> wr_en=0, busy=0, err=0 on the next cycle. A new start then captures a full 32-pixel frame correctly.
- Frame with 5 active lines -> writes 0..31 only, 8 extra pixels dropped, err=1, lines=5.
- Full default loopback from vga (640x480) -> 307200 writes, last wr_addr=307199, err=0.
